ex_stage_fwd_mc: RTL

//   Registered execute stage for the RV32 pipeline. Selects operands from the register file or

---
 rtl/ex_stage_fwd_mc.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_fwd_mc.sv
// ex_stage_fwd_mc: RV32 execute stage with operand forwarding, a single-cycle ALU and an
// optional iterative shift-add multiplier, built only when EX_MUL_EN is defined.
module ex_stage_fwd_mc #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int FSEL_W = $clog2(NFWD + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [XLEN-1:0]        imm,
  input  logic                   alub_sel,
  input  logic [3:0]             alu_sel,
  input  logic [FSEL_W-1:0]      fwd_a,
  input  logic [FSEL_W-1:0]      fwd_b,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  input  logic [4:0]             rd_in,
  input  logic                   rd_we_in,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_alu_c,
  output logic                   out_branch,
  output logic [XLEN-1:0]        out_store,
  output logic [4:0]             out_rd,
  output logic                   out_rd_we,
  output logic                   out_illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_BGE  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;

  // Handshake: an instruction transfers on a rising edge where in_valid & in_ready & ~flush;
  // upstream must hold it stable while in_ready is low. out_valid is a one-cycle pulse.
  logic accept;
  assign accept = in_valid & in_ready & ~flush;

  logic [XLEN-1:0] op_a, op_b, op_b_fwd;

  // Out-of-range selects fall back to the register file value.
  always_comb begin
    op_a     = rs1_data;
    op_b_fwd = rs2_data;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_a == FSEL_W'(k)) op_a     = fwd_data[(k-1)*XLEN +: XLEN];
      if (fwd_b == FSEL_W'(k)) op_b_fwd = fwd_data[(k-1)*XLEN +: XLEN];
    end
    op_b = alub_sel ? imm : op_b_fwd;
  end

  logic [XLEN-1:0] diff, alu_res;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, alu_br, alu_ill, is_mul;

  assign diff  = op_a - op_b;
  assign shamt = op_b[SHW-1:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (alu_sel)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_BEQ: begin
        alu_res = diff;
        alu_br  = (op_a == op_b);
      end
      OP_BNE: begin
        alu_res = diff;
        alu_br  = (op_a != op_b);
      end
      OP_BLT: begin
        alu_res = diff;
        alu_br  = lt_s;
      end
      OP_BGE: begin
        alu_res = diff;
        alu_br  = ~lt_s;
      end
      OP_MUL: begin
`ifdef EX_MUL_EN
        is_mul  = 1'b1;
`else
        alu_ill = 1'b1;
`endif
      end
      default: alu_ill = 1'b1;
    endcase
  end

  logic            mul_done;
  logic [XLEN-1:0] mul_res, mul_store;
  logic [4:0]      mul_rd;
  logic            mul_rd_we;

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [XLEN-1:0] mstore_q, mstore_d, acc_step;
  logic [4:0]      mrd_q, mrd_d;
  logic            mrd_we_q, mrd_we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mstore_q <= '0;
      mrd_q    <= '0;
      mrd_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mstore_q <= mstore_d;
      mrd_q    <= mrd_d;
      mrd_we_q <= mrd_we_d;
    end
  end

  // One shift-add step per MUL cycle; the final step's sum goes straight to the output register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mstore_d = mstore_q;
    mrd_d    = mrd_q;
    mrd_we_d = mrd_we_q;
    mul_done = 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          mstore_d = op_b_fwd;
          mrd_d    = rd_in;
          mrd_we_d = rd_we_in;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN - 1)) begin
            state_d  = S_IDLE;
            mul_done = 1'b1;
          end
        end
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mul_res   = acc_step;
  assign mul_store = mstore_q;
  assign mul_rd    = mrd_q;
  assign mul_rd_we = mrd_we_q;
`else
  assign in_ready  = 1'b1;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_store = '0;
  assign mul_rd    = '0;
  assign mul_rd_we = 1'b0;
`endif

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_alu_c_q, out_alu_c_d;
  logic            out_branch_q, out_branch_d;
  logic [XLEN-1:0] out_store_q, out_store_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_rd_we_q, out_rd_we_d;
  logic            out_illegal_q, out_illegal_d;

  // Payload holds between results; only valid and write-enable drop back to zero.
  always_comb begin
    out_valid_d   = 1'b0;
    out_rd_we_d   = 1'b0;
    out_alu_c_d   = out_alu_c_q;
    out_branch_d  = out_branch_q;
    out_store_d   = out_store_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (mul_done) begin
      out_valid_d   = 1'b1;
      out_alu_c_d   = mul_res;
      out_branch_d  = 1'b0;
      out_store_d   = mul_store;
      out_rd_d      = mul_rd;
      out_rd_we_d   = mul_rd_we;
      out_illegal_d = 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_d   = 1'b1;
      out_alu_c_d   = alu_res;
      out_branch_d  = alu_br;
      out_store_d   = op_b_fwd;
      out_rd_d      = rd_in;
      out_rd_we_d   = rd_we_in & ~alu_ill;
      out_illegal_d = alu_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_alu_c_q   <= '0;
      out_branch_q  <= 1'b0;
      out_store_q   <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_alu_c_q   <= out_alu_c_d;
      out_branch_q  <= out_branch_d;
      out_store_q   <= out_store_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_alu_c   = out_alu_c_q;
  assign out_branch  = out_branch_q;
  assign out_store   = out_store_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_illegal = out_illegal_q;

endmodule
